// File: rtl/lcd_ctrl_if.sv
// rtl/lcd_ctrl_if.sv - LSU-side store strobe and LCD bus bundle for lcd_ctrl
//
// Purpose: groups the store handshake coming from the LSU and every signal the
// controller drives back (LCD pins and status) into one bundle.
// Signals:
//   lcd_wr     1   one-cycle store strobe into the LCD window
//   lcd_wdata  32  store data: [31]=display power, [8]=RS, [7:0]=byte
//   lcd_data   8   LCD data bus
//   lcd_rs     1   register select
//   lcd_rw     1   read/write, always 0
//   lcd_en     1   enable strobe
//   lcd_on     1   LCD power/backlight
//   busy       1   transaction or init in progress
//   init_done  1   init sequence complete
//   drop       1   sticky: a store was rejected while busy
//   status     32  {29'b0, drop, init_done, busy}
// Modports: master = LSU side, slave = controller side.

interface lcd_ctrl_if;
    logic        lcd_wr;
    logic [31:0] lcd_wdata;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_en;
    logic        lcd_on;
    logic        busy;
    logic        init_done;
    logic        drop;
    logic [31:0] status;

    modport master (
        output lcd_wr, lcd_wdata,
        input  lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on,
        input  busy, init_done, drop, status
    );

    modport slave (
        input  lcd_wr, lcd_wdata,
        output lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on,
        output busy, init_done, drop, status
    );
endinterface

// File: rtl/lcd_ctrl.sv
// rtl/lcd_ctrl.sv - HD44780-style character LCD controller with autonomous init
//
// Purpose: turns each LSU store into a timed RS/RW/EN/DATA write cycle, runs the
// power-up init sequence after reset and exposes a busy/status word.
// Ports:
//   i_clk    in  system clock, rising edge
//   i_reset  in  asynchronous, active-low reset
//   lcd      slave side of lcd_ctrl_if (store strobe in, LCD pins and status out)
// Every output is a register (status is a plain concatenation of registers).

module lcd_ctrl #(
    parameter int T_PWRUP = 750000,
    parameter int T_SETUP = 2,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 2,
    parameter int T_CMD   = 2000,
    parameter int T_CLR   = 82000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    lcd_ctrl_if.slave   lcd
);

    localparam int M1    = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
    localparam int M2    = (M1 > T_CMD) ? M1 : T_CMD;
    localparam int M3    = (M2 > T_EN) ? M2 : T_EN;
    localparam int M4    = (M3 > T_SETUP) ? M3 : T_SETUP;
    localparam int T_MAX = (M4 > T_HOLD) ? M4 : T_HOLD;
    localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [CW-1:0] L_PWRUP = CW'(T_PWRUP - 1);
    localparam logic [CW-1:0] L_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] L_EN    = CW'(T_EN - 1);
    localparam logic [CW-1:0] L_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] L_CMD   = CW'(T_CMD - 1);
    localparam logic [CW-1:0] L_CLR   = CW'(T_CLR - 1);

    localparam logic [2:0] S_PWRUP     = 3'd0;
    localparam logic [2:0] S_INIT_LOAD = 3'd1;
    localparam logic [2:0] S_SETUP     = 3'd2;
    localparam logic [2:0] S_EN_HI     = 3'd3;
    localparam logic [2:0] S_HOLD      = 3'd4;
    localparam logic [2:0] S_WAIT      = 3'd5;
    localparam logic [2:0] S_IDLE      = 3'd6;

    localparam logic [2:0] LAST_IDX = 3'd5;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    data_q;
    logic          rs_q;
    logic          en_q;
    logic          on_q;
    logic          busy_q;
    logic          done_q;
    logic          drop_q;
    logic [7:0]    rom_byte;
    logic          is_slow;
    logic          cnt_zero;
    logic          unused_wdata;

    // Init ROM: function set x3, display on, clear, entry mode.
    always_comb begin
        rom_byte = 8'h06;
        case (idx)
            3'd0, 3'd1, 3'd2: rom_byte = 8'h38;
            3'd3:             rom_byte = 8'h0C;
            3'd4:             rom_byte = 8'h01;
            default:          rom_byte = 8'h06;
        endcase
    end

    // Clear display and return home need the long settle time.
    assign is_slow  = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));
    assign cnt_zero = (cnt == '0);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state  <= S_PWRUP;
            cnt    <= L_PWRUP;
            idx    <= 3'd0;
            data_q <= 8'h00;
            rs_q   <= 1'b0;
            en_q   <= 1'b0;
            on_q   <= 1'b0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            // busy_q is low only in IDLE, so any store seen while it is high is lost.
            if (lcd.lcd_wr && busy_q) begin
                drop_q <= 1'b1;
            end
            case (state)
                S_PWRUP: begin
                    if (cnt_zero) state <= S_INIT_LOAD;
                    else          cnt   <= cnt - 1'b1;
                end
                S_INIT_LOAD: begin
                    data_q <= rom_byte;
                    rs_q   <= 1'b0;
                    cnt    <= L_SETUP;
                    state  <= S_SETUP;
                end
                S_SETUP: begin
                    if (cnt_zero) begin
                        en_q  <= 1'b1;
                        cnt   <= L_EN;
                        state <= S_EN_HI;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_EN_HI: begin
                    if (cnt_zero) begin
                        en_q  <= 1'b0;
                        cnt   <= L_HOLD;
                        state <= S_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt_zero) begin
                        cnt   <= is_slow ? L_CLR : L_CMD;
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 1'b1;
                    end else if (done_q || (idx == LAST_IDX)) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_INIT_LOAD;
                    end
                end
                S_IDLE: begin
                    if (lcd.lcd_wr && !busy_q) begin
                        data_q <= lcd.lcd_wdata[7:0];
                        rs_q   <= lcd.lcd_wdata[8];
                        on_q   <= lcd.lcd_wdata[31];
                        busy_q <= 1'b1;
                        cnt    <= L_SETUP;
                        state  <= S_SETUP;
                    end
                end
                default: begin
                    en_q   <= 1'b0;
                    busy_q <= 1'b1;
                    cnt    <= L_PWRUP;
                    state  <= S_PWRUP;
                end
            endcase
        end
    end

    assign unused_wdata = ^lcd.lcd_wdata[30:9];

    assign lcd.lcd_data  = data_q;
    assign lcd.lcd_rs    = rs_q;
    assign lcd.lcd_rw    = 1'b0;
    assign lcd.lcd_en    = en_q;
    assign lcd.lcd_on    = on_q;
    assign lcd.busy      = busy_q;
    assign lcd.init_done = done_q;
    assign lcd.drop      = drop_q;
    assign lcd.status    = {29'b0, drop_q, done_q, busy_q};

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb/tb_lcd_ctrl.sv - scoreboard testbench for lcd_ctrl

module tb_lcd_ctrl;

    localparam int TP   = 20;
    localparam int TS   = 1;
    localparam int TE   = 3;
    localparam int TH   = 1;
    localparam int TCMD = 5;
    localparam int TCLR = 10;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         gap;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    lcd_ctrl_if bus();

    lcd_ctrl #(
        .T_PWRUP(TP), .T_SETUP(TS), .T_EN(TE),
        .T_HOLD(TH), .T_CMD(TCMD), .T_CLR(TCLR)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .lcd    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input logic rs, input logic [7:0] data, input int gap);
        exp_t e;
        e.rs = rs;
        e.data = data;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic push_init();
        logic [7:0] rom [6];
        int gap;
        rom = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        for (int i = 0; i < 6; i++) begin
            if (i == 0)              gap = TP + 1 + TS;
            else if (rom[i-1] == 1)  gap = TH + TCLR + 1 + TS;
            else                     gap = TH + TCMD + 1 + TS;
            push_exp(1'b0, rom[i], gap);
        end
    endtask

    // Pulse monitor: pops one expectation per EN rising edge.
    logic       en_prev = 1'b0;
    int         low_cnt = 0;
    int         hi_cnt = 0;
    logic [7:0] cap_data;
    logic       cap_rs;
    logic       unstable;

    always @(negedge clk) begin
        exp_t e;
        if (bus.lcd_en && !en_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_data", {24'b0, bus.lcd_data}, {24'b0, e.data});
                check("pulse_rs", {31'b0, bus.lcd_rs}, {31'b0, e.rs});
                if (e.gap >= 0) check("pulse_gap", low_cnt, e.gap);
            end
            hi_cnt = 1;
            cap_data = bus.lcd_data;
            cap_rs = bus.lcd_rs;
            unstable = 1'b0;
        end else if (bus.lcd_en) begin
            hi_cnt++;
            if (bus.lcd_data !== cap_data || bus.lcd_rs !== cap_rs) unstable = 1'b1;
        end else if (en_prev) begin
            if (rst) begin
                check("pulse_width", hi_cnt, TE);
                check("pulse_stable", {31'b0, unstable}, 32'd0);
            end
            low_cnt = 1;
        end else begin
            low_cnt++;
        end
        if (!rst) low_cnt = 0;
        en_prev = bus.lcd_en;
    end

    // Called at a negedge: strobe wr for exactly one rising edge.
    task automatic start(input logic [31:0] d);
        bus.lcd_wr = 1'b1;
        bus.lcd_wdata = d;
        @(posedge clk);
        #1 bus.lcd_wr = 1'b0;
    endtask

    // Measures the busy window after an accept edge; optionally injects a
    // second store inj cycles after the accept and checks status during busy.
    task automatic measure(input int inj, input logic [31:0] inj_d,
                           output int busy_len, output int en_first, output int en_len);
        busy_len = 0;
        en_first = -1;
        en_len = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k == inj + 1) bus.lcd_wr = 1'b0;
            if (!bus.busy) break;
            if (k == inj + 2) begin
                check("busy_status", bus.status, 32'h7);
                check("busy_data_kept", {24'b0, bus.lcd_data}, 32'h41);
            end
            busy_len++;
            if (bus.lcd_en) begin
                if (en_first < 0) en_first = k;
                en_len++;
            end
            if (k == inj - 1) begin
                bus.lcd_wr = 1'b1;
                bus.lcd_wdata = inj_d;
            end
        end
        if (busy_len >= 200) check("busy_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (!bus.init_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, bus.init_done}, 32'd1);
    endtask

    initial begin
        int bl, ef, el;
        bus.lcd_wr = 1'b0;
        bus.lcd_wdata = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_status", bus.status, 32'h1);
        check("rst_en", {31'b0, bus.lcd_en}, 32'd0);
        check("rst_data", {24'b0, bus.lcd_data}, 32'd0);
        check("rst_rw", {31'b0, bus.lcd_rw}, 32'd0);
        check("rst_on", {31'b0, bus.lcd_on}, 32'd0);

        // 1. Init sequence, including a store during power-up wait
        push_init();
        @(posedge clk);
        #1 rst = 1'b1;
        wait_init("init_done");
        @(negedge clk);
        check("init_status", bus.status, 32'h2);
        check("init_pulses_left", exp_q.size(), 32'd0);

        // 2. Data write
        push_exp(1'b1, 8'h41, -1);
        start(32'h8000_0141);
        measure(-10, 32'h0, bl, ef, el);
        check("data_busy_len", bl, TS + TE + TH + TCMD);
        check("data_en_first", ef, TS);
        check("data_en_len", el, TE);
        check("data_on", {31'b0, bus.lcd_on}, 32'd1);
        check("data_rs", {31'b0, bus.lcd_rs}, 32'd1);
        check("data_drop", {31'b0, bus.drop}, 32'd0);

        // 3. Clear display
        @(negedge clk);
        push_exp(1'b0, 8'h01, -1);
        start(32'h0000_0001);
        measure(-10, 32'h0, bl, ef, el);
        check("clr_busy_len", bl, TS + TE + TH + TCLR);
        check("clr_on", {31'b0, bus.lcd_on}, 32'd0);
        check("clr_data", {24'b0, bus.lcd_data}, 32'h01);

        // 4. Store while busy is rejected
        @(negedge clk);
        push_exp(1'b1, 8'h41, -1);
        start(32'h8000_0141);
        measure(3, 32'h0000_0142, bl, ef, el);
        check("rej_busy_len", bl, TS + TE + TH + TCMD);
        check("rej_status_after", bus.status, 32'h6);
        check("rej_on_kept", {31'b0, bus.lcd_on}, 32'd1);

        // 5. Back-to-back on the first idle cycle
        push_exp(1'b1, 8'h43, TH + TCMD + 1 + TS);
        start(32'h8000_0143);
        measure(-10, 32'h0, bl, ef, el);
        check("b2b_busy_len", bl, TS + TE + TH + TCMD);
        check("b2b_en_first", ef, TS);
        check("b2b_drop", {31'b0, bus.drop}, 32'd1);
        repeat (3) @(negedge clk);
        check("b2b_pulses_left", exp_q.size(), 32'd0);

        // 6. Reset in the middle of an EN pulse
        push_exp(1'b1, 8'h44, -1);
        start(32'h8000_0144);
        begin
            int n;
            n = 0;
            while (!bus.lcd_en && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("mid_en_high", {31'b0, bus.lcd_en}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_en", {31'b0, bus.lcd_en}, 32'd0);
        check("mid_rst_status", bus.status, 32'h1);
        check("mid_rst_data", {24'b0, bus.lcd_data}, 32'd0);
        check("mid_rst_on", {31'b0, bus.lcd_on}, 32'd0);
        exp_q.delete();
        push_init();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        wait_init("reinit_done");
        @(negedge clk);
        check("reinit_pulses_left", exp_q.size(), 32'd0);
        check("reinit_status", bus.status, 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
